// File: rtl/los_biphase_tx.sv
// LOS downlink serializer: bytes out MSB-first as NRZ SDAT, mid-bit SCLK and biphase-mark.
// Define LOS_CRC_EN to append a CRC-16-CCITT trailer (high byte, then low byte) to each frame.
module los_biphase_tx #(
  parameter int unsigned BIT_CYCLES = 32,
  parameter logic [7:0]  FILL_BYTE  = 8'h00,
  parameter int unsigned UCNT_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [7:0]        dat_i,
  input  logic              dat_valid_i,
  input  logic              dat_last_i,
  output logic              dat_ready_o,
  output logic              SDAT,
  output logic              SCLK,
  output logic              BIPHASE,
  output logic              busy_o,
  output logic              underrun_o,
  output logic [UCNT_W-1:0] ucount_o
);

  localparam int unsigned  PW      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYCLES - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(BIT_CYCLES / 2);
  localparam logic [PW-1:0] PH_PRE  = PW'(BIT_CYCLES / 2 - 1);

  generate
    if (BIT_CYCLES < 4 || (BIT_CYCLES % 2) != 0) begin : g_bad_bit_cycles
      $error("los_biphase_tx: BIT_CYCLES must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {StOff, StFill, StData, StCrc} state_e;

  state_e            r_state;
  logic [PW-1:0]     r_phase;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_bp;
  logic              r_under;
  logic              r_open;
  logic [UCNT_W-1:0] r_ucnt;

  logic       w_b;
  logic       w_accept;
  logic       w_crc_pend;
  logic [7:0] w_crc_byte;

  assign w_b = (r_state == StOff) || ((r_phase == PH_LAST) && (r_bit == 3'd7));
  // Reset term keeps ready low while reset is held, even though OFF is a boundary.
  assign dat_ready_o = w_b & en_i & rst_n_i & ~w_crc_pend;
  assign w_accept    = dat_ready_o & dat_valid_i;

`ifdef LOS_CRC_EN
  logic [15:0] r_crc;
  logic [1:0]  r_crc_left;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 7; i >= 0; i--) begin
      x = (x[15] ^ d[i]) ? ((x << 1) ^ 16'h1021) : (x << 1);
    end
    return x;
  endfunction

  assign w_crc_pend = (r_crc_left != 2'd0);
  assign w_crc_byte = (r_crc_left == 2'd2) ? r_crc[15:8] : r_crc[7:0];

  // A byte accepted outside an open frame starts a new frame and reseeds the CRC.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_crc      <= 16'hFFFF;
      r_crc_left <= 2'd0;
    end else if (w_b) begin
      if (!en_i) begin
        r_crc_left <= 2'd0;
      end else if (w_crc_pend) begin
        r_crc_left <= r_crc_left - 2'd1;
      end else if (w_accept) begin
        r_crc <= crc_step(r_open ? r_crc : 16'hFFFF, dat_i);
        if (dat_last_i) r_crc_left <= 2'd2;
      end else if (r_open) begin
        r_crc <= crc_step(r_crc, FILL_BYTE);
      end
    end
  end
`else
  assign w_crc_pend = 1'b0;
  assign w_crc_byte = FILL_BYTE;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= StOff;
      r_phase <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_bp    <= 1'b0;
      r_under <= 1'b0;
      r_open  <= 1'b0;
      r_ucnt  <= '0;
    end else begin
      r_under <= 1'b0;
      if (w_b) begin
        r_phase <= '0;
        r_bit   <= '0;
        if (!en_i) begin
          r_state <= StOff;
          r_shift <= '0;
          r_open  <= 1'b0;
        end else begin
          r_bp <= ~r_bp;
          if (w_crc_pend) begin
            r_state <= StCrc;
            r_shift <= w_crc_byte;
          end else if (w_accept) begin
            r_state <= StData;
            r_shift <= dat_i;
            r_open  <= ~dat_last_i;
          end else begin
            r_shift <= FILL_BYTE;
            if (r_open) begin
              r_state <= StData;
              r_under <= 1'b1;
              if (r_ucnt != {UCNT_W{1'b1}}) r_ucnt <= r_ucnt + UCNT_W'(1);
            end else begin
              r_state <= StFill;
            end
          end
        end
      end else if (r_phase == PH_LAST) begin
        r_phase <= '0;
        r_bit   <= r_bit + 3'd1;
        r_shift <= {r_shift[6:0], 1'b0};
        r_bp    <= ~r_bp;
      end else begin
        r_phase <= r_phase + PW'(1);
        if ((r_phase == PH_PRE) && r_shift[7]) r_bp <= ~r_bp;
      end
    end
  end

  assign SDAT       = r_shift[7];
  assign SCLK       = (r_state != StOff) && (r_phase >= PH_MID);
  assign BIPHASE    = r_bp;
  assign busy_o     = (r_state == StData) || (r_state == StCrc);
  assign underrun_o = r_under;
  assign ucount_o   = r_ucnt;

endmodule
